// File: rtl/sincos_cordic_if.sv
// Handshake and result bundle between an angle source and the CORDIC sin/cos generator.
interface sincos_cordic_if #(
   parameter int unsigned N = 10
);

   logic                start;
   logic        [N-1:0] theta;
   logic                busy;
   logic                valid;
   logic signed [N-1:0] sin;
   logic signed [N-1:0] cos;

   modport master (
      output start,
      output theta,
      input  busy,
      input  valid,
      input  sin,
      input  cos
   );

   modport slave (
      input  start,
      input  theta,
      output busy,
      output valid,
      output sin,
      output cos
   );

endinterface

// File: rtl/sincos_cordic.sv
// Iterative CORDIC sine/cosine generator: unsigned angle in, signed Q1.F sin/cos out,
// one result per conversion under a start/valid handshake.
module sincos_cordic #(
   parameter int unsigned N    = 10,
   parameter int unsigned F    = 9,
   parameter int unsigned ITER = 12
) (
   input logic            clk,
   input logic            rst_n,
   sincos_cordic_if.slave bus
);

   // Guard bits below the output LSB; x/y carry two extra integer bits for CORDIC growth.
   localparam int unsigned G  = 4;
   localparam int unsigned W  = N + G + 2;
   localparam int unsigned ZW = N + G + 1;
   localparam int unsigned IW = $clog2(ITER);
   localparam real         Pi = 3.14159265358979323846;

   // Start vector pre-scaled by 1/K so the rotated vector lands at unit magnitude.
   localparam logic signed [W-1:0] X0 = W'(longint'(0.6072529350 * (2.0 ** (F + G))));

   localparam logic signed [W:0] OutMax = (W + 1)'(2 ** (N - 1) - 1);
   localparam logic signed [W:0] OutMin = -((W + 1)'(2 ** (N - 1)));

   typedef enum logic [1:0] {
      StIdle,
      StIterate,
      StFinish
   } state_e;

   state_e                state_q, state_d;
   logic signed [W-1:0]   x_q, x_d;
   logic signed [W-1:0]   y_q, y_d;
   logic signed [ZW-1:0]  z_q, z_d;
   logic        [1:0]     quad_q, quad_d;
   logic        [IW-1:0]  i_q, i_d;
   logic signed [N-1:0]   sin_q, sin_d;
   logic signed [N-1:0]   cos_q, cos_d;
   logic                  valid_q, valid_d;

   logic signed [W-1:0]   xs, ys;
   logic signed [W-1:0]   mc, ms;
   logic signed [ZW-1:0]  atan_tab [ITER];

   // atan(2^-k) expressed in units of 2^-(N+G) turn, rounded to nearest.
   function automatic logic signed [ZW-1:0] atan_code(input int k);
      real a;
      a = $atan(1.0 / (2.0 ** k)) / (2.0 * Pi) * (2.0 ** (N + G));
      return ZW'(longint'(a));
   endfunction

   // Drop the guard bits with round-half-up, then clamp to the Q1.F range.
   function automatic logic signed [N-1:0] round_sat(input logic signed [W-1:0] v);
      logic signed [W:0] t;
      t = (W + 1)'(v) + (W + 1)'(2 ** (G - 1));
      t = t >>> G;
      if (t > OutMax) begin
         return OutMax[N-1:0];
      end else if (t < OutMin) begin
         return OutMin[N-1:0];
      end
      return t[N-1:0];
   endfunction

   for (genvar g = 0; g < int'(ITER); g++) begin : g_atan
      assign atan_tab[g] = atan_code(g);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: idle until start, ITER micro-rotations, one finish cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (bus.start) state_d = StIterate;
         StIterate: if (i_q == IW'(ITER - 1)) state_d = StFinish;
         StFinish:  state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Datapath next-state: load on accept, rotate while iterating, map and narrow on finish.
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      quad_d  = quad_q;
      i_d     = i_q;
      sin_d   = sin_q;
      cos_d   = cos_q;
      valid_d = 1'b0;
      xs      = x_q >>> i_q;
      ys      = y_q >>> i_q;
      mc      = x_q;
      ms      = y_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               x_d    = X0;
               y_d    = '0;
               // Residual angle within the quadrant, in [0, 90 deg).
               z_d    = ZW'({bus.theta[N-3:0], {G{1'b0}}});
               quad_d = bus.theta[N-1:N-2];
               i_d    = '0;
            end
         end
         StIterate: begin
            if (!z_q[ZW-1]) begin
               x_d = x_q - ys;
               y_d = y_q + xs;
               z_d = z_q - atan_tab[i_q];
            end else begin
               x_d = x_q + ys;
               y_d = y_q - xs;
               z_d = z_q + atan_tab[i_q];
            end
            i_d = i_q + 1'b1;
         end
         StFinish: begin
            // Negation stays at width W, where |x|,|y| never reach the negative limit.
            case (quad_q)
               2'd0: begin
                  mc = x_q;
                  ms = y_q;
               end
               2'd1: begin
                  mc = -y_q;
                  ms = x_q;
               end
               2'd2: begin
                  mc = -x_q;
                  ms = -y_q;
               end
               default: begin
                  mc = y_q;
                  ms = -x_q;
               end
            endcase
            cos_d   = round_sat(mc);
            sin_d   = round_sat(ms);
            valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath and result registers; reset discards any partial conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         quad_q  <= '0;
         i_q     <= '0;
         sin_q   <= '0;
         cos_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         quad_q  <= quad_d;
         i_q     <= i_d;
         sin_q   <= sin_d;
         cos_q   <= cos_d;
         valid_q <= valid_d;
      end
   end

   // Outputs: busy decoded from state, results straight from registers.
   always_comb begin
      bus.busy  = (state_q != StIdle);
      bus.valid = valid_q;
      bus.sin   = sin_q;
      bus.cos   = cos_q;
   end

endmodule
